clp_output_accum: RTL and testbench

//  Producer side of the CLP result write path: gathers Tm-lane partial sums from the conv array, accumulates

---
 rtl/clp_accum_pkg.sv | 16 +
 rtl/clp_accum_ram.sv | 23 ++
 rtl/clp_output_accum.sv | 172 +++++++++++++++++
 tb/tb_clp_output_accum.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clp_accum_pkg.sv
// Shared types and helpers for the CLP output accumulator.
package clp_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Bit offset of a lane within a packed Tm-lane word.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned fw);
    return lane * fw;
  endfunction

endpackage

// File: rtl/clp_accum_ram.sv
// Simple dual-port accumulation buffer: one write port, one registered read port.
module clp_accum_ram #(
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Read-during-write to the same address returns the old word; the top forwards.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/clp_output_accum.sv
// Accumulates Tm-lane partial sums over tile_count passes and emits final packed words.
module clp_output_accum
  import clp_accum_pkg::*;
#(
  parameter int unsigned Tm             = 8,
  parameter int unsigned FEATURE_WIDTH  = 32,
  parameter int unsigned PIX_ADDR_WIDTH = 10,
  parameter int unsigned TILE_CNT_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [TILE_CNT_WIDTH-1:0]     tile_count,
  input  logic [PIX_ADDR_WIDTH:0]       pixel_count,
  input  logic                          relu_en,
  input  logic                          psum_valid,
  input  logic [Tm*FEATURE_WIDTH-1:0]   psum_data,
  output logic                          busy,
  output logic                          CLP_output_flag,
  output logic [Tm*FEATURE_WIDTH-1:0]   CLP_output,
  output logic                          done,
  output logic                          ovf_sticky
);

  localparam int unsigned FW = FEATURE_WIDTH;
  localparam int unsigned WW = Tm * FW;
  localparam logic [FW-1:0] LANE_MAX = {1'b0, {(FW-1){1'b1}}};
  localparam logic [FW-1:0] LANE_MIN = {1'b1, {(FW-1){1'b0}}};

  state_t                    r_state, w_state_nxt;
  logic [PIX_ADDR_WIDTH-1:0] r_pix_cnt;
  logic [PIX_ADDR_WIDTH:0]   r_pix_last;
  logic [TILE_CNT_WIDTH-1:0] r_pass_cnt, r_pass_last;
  logic                      r_relu, r_drain_cnt;

  logic                      r_s1_vld, r_s1_first, r_s1_final;
  logic [PIX_ADDR_WIDTH-1:0] r_s1_addr;
  logic [WW-1:0]             r_s1_psum;
  logic                      r_fwd;
  logic [WW-1:0]             r_fwd_data;

  logic                      w_acc, w_pix_wrap, w_pass_final, w_start_ok;
  logic [WW-1:0]             w_rdata, w_opnd, w_sum, w_out;
  logic                      w_ovf;
  logic [FW-1:0]             w_a, w_b, w_lane;
  logic [FW:0]               w_s;

  assign w_acc        = (r_state == ST_ACCUM) && psum_valid;
  assign w_pix_wrap   = ({1'b0, r_pix_cnt} == r_pix_last);
  assign w_pass_final = (r_pass_cnt == r_pass_last);
  assign w_start_ok   = (r_state == ST_IDLE) && start;
  assign w_opnd       = r_fwd ? r_fwd_data : w_rdata;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = (pixel_count == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: begin
        busy = 1'b1;
        if (w_acc && w_pix_wrap && w_pass_final) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (r_drain_cnt) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pix_cnt   <= '0;
      r_pix_last  <= '0;
      r_pass_cnt  <= '0;
      r_pass_last <= '0;
      r_relu      <= 1'b0;
      r_drain_cnt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= (r_state == ST_DRAIN);
      if (w_start_ok) begin
        r_pix_last  <= pixel_count - 1'b1;
        r_pass_last <= (tile_count == '0) ? '0 : tile_count - 1'b1;
        r_relu      <= relu_en;
        r_pix_cnt   <= '0;
        r_pass_cnt  <= '0;
      end else if (w_acc) begin
        if (w_pix_wrap) begin
          r_pix_cnt  <= '0;
          r_pass_cnt <= r_pass_cnt + 1'b1;
        end else begin
          r_pix_cnt  <= r_pix_cnt + 1'b1;
        end
      end
    end
  end

  // Pass 0 ignores the buffer so stale data from an earlier or aborted job never leaks in.
  always_comb begin
    w_sum  = '0;
    w_out  = '0;
    w_ovf  = 1'b0;
    w_a    = '0;
    w_b    = '0;
    w_s    = '0;
    w_lane = '0;
    for (int unsigned i = 0; i < Tm; i++) begin
      w_a = r_s1_first ? '0 : w_opnd[lane_lo(i, FW) +: FW];
      w_b = r_s1_psum[lane_lo(i, FW) +: FW];
      w_s = {w_a[FW-1], w_a} + {w_b[FW-1], w_b};
      if (w_s[FW] != w_s[FW-1]) begin
        w_lane = w_s[FW] ? LANE_MIN : LANE_MAX;
        w_ovf  = 1'b1;
      end else begin
        w_lane = w_s[FW-1:0];
      end
      w_sum[lane_lo(i, FW) +: FW] = w_lane;
      w_out[lane_lo(i, FW) +: FW] = (r_relu && w_lane[FW-1]) ? '0 : w_lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld        <= 1'b0;
      r_s1_first      <= 1'b0;
      r_s1_final      <= 1'b0;
      r_s1_addr       <= '0;
      r_s1_psum       <= '0;
      r_fwd           <= 1'b0;
      r_fwd_data      <= '0;
      CLP_output_flag <= 1'b0;
      CLP_output      <= '0;
      ovf_sticky      <= 1'b0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_first <= (r_pass_cnt == '0);
        r_s1_final <= w_pass_final;
        r_s1_addr  <= r_pix_cnt;
        r_s1_psum  <= psum_data;
      end
      // Same-address back-to-back beats: the RAM read misses this cycle's write.
      r_fwd      <= r_s1_vld && w_acc && (r_s1_addr == r_pix_cnt);
      r_fwd_data <= w_sum;
      CLP_output_flag <= r_s1_vld && r_s1_final;
      if (r_s1_vld && r_s1_final) CLP_output <= w_out;
      if (w_start_ok)                ovf_sticky <= 1'b0;
      else if (r_s1_vld && w_ovf)    ovf_sticky <= 1'b1;
    end
  end

  clp_accum_ram #(
    .WIDTH      (WW),
    .ADDR_WIDTH (PIX_ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (r_s1_vld),
    .i_waddr (r_s1_addr),
    .i_wdata (w_sum),
    .i_re    (w_acc),
    .i_raddr (r_pix_cnt),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_clp_output_accum.sv
// Self-checking bench for clp_output_accum: vector table, directed sequences, random jobs vs model.
module tb_clp_output_accum;

  localparam int TM  = 8;
  localparam int FW  = 32;
  localparam int PAW = 4;
  localparam int TCW = 6;
  localparam int PCW = PAW + 1;
  localparam int WW  = TM * FW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [TCW-1:0] tile_count = '0;
  logic [PCW-1:0] pixel_count = '0;
  logic           relu_en = 1'b0;
  logic           psum_valid = 1'b0;
  logic [WW-1:0]  psum_data = '0;
  logic           busy, CLP_output_flag, done, ovf_sticky;
  logic [WW-1:0]  CLP_output;

  clp_output_accum #(
    .Tm             (TM),
    .FEATURE_WIDTH  (FW),
    .PIX_ADDR_WIDTH (PAW),
    .TILE_CNT_WIDTH (TCW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .tile_count      (tile_count),
    .pixel_count     (pixel_count),
    .relu_en         (relu_en),
    .psum_valid      (psum_valid),
    .psum_data       (psum_data),
    .busy            (busy),
    .CLP_output_flag (CLP_output_flag),
    .CLP_output      (CLP_output),
    .done            (done),
    .ovf_sticky      (ovf_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WW-1:0] got_data[$];
  int            got_cyc[$];
  int            done_cnt, done_cyc;
  logic          done_busy;
  int            checks = 0, failures = 0;
  logic [WW-1:0] pm [0:3][0:7];

  always @(negedge clk) begin
    if (CLP_output_flag) begin
      got_data.push_back(CLP_output);
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [WW-1:0] w;
    for (int l = 0; l < TM; l++) w[l*FW +: FW] = $urandom;
    return w;
  endfunction

  function automatic logic [FW-1:0] lane_of(input logic [WW-1:0] w, input int l);
    return w[l*FW +: FW];
  endfunction

  // Reference: saturating running sum per pass, ReLU on the final value only.
  function automatic logic [FW-1:0] model_lane(input int te, input int x, input int l,
                                               input bit relu, output bit sat);
    longint acc, lmax, lmin;
    lmax = (longint'(1) <<< (FW - 1)) - 1;
    lmin = -(longint'(1) <<< (FW - 1));
    acc  = 0;
    sat  = 1'b0;
    for (int p = 0; p < te; p++) begin
      acc = acc + longint'($signed(lane_of(pm[p][x], l)));
      if (acc > lmax) begin acc = lmax; sat = 1'b1; end
      if (acc < lmin) begin acc = lmin; sat = 1'b1; end
    end
    if (relu && acc < 0) acc = 0;
    return FW'(acc);
  endfunction

  task automatic run_job(input int tiles, input int npix, input bit relu,
                         input int gap_pct, input bit poke);
    int   te, s_cyc, k, nb, exp_done;
    int   bcyc[$];
    bit   eovf, sat;
    logic [WW-1:0] ew;
    te = (tiles == 0) ? 1 : tiles;
    got_data.delete();
    got_cyc.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    tile_count  = TCW'(tiles);
    pixel_count = PCW'(npix);
    relu_en     = relu;
    start       = 1'b1;
    s_cyc       = cyc;
    @(posedge clk); #1;
    start       = 1'b0;
    tile_count  = TCW'($urandom);
    pixel_count = PCW'($urandom);
    relu_en     = 1'($urandom);
    @(negedge clk);
    chk("busy_after_start", busy, npix > 0);
    chk("ovf_after_start", ovf_sticky, 0);
    nb = 0;
    for (int p = 0; p < te; p++) begin
      for (int x = 0; x < npix; x++) begin
        k = 0;
        while (k < 3 && $urandom_range(0, 99) < gap_pct) begin
          psum_valid = 1'b0;
          psum_data  = rnd_word();
          @(posedge clk); #1;
          k++;
        end
        psum_valid = 1'b1;
        psum_data  = pm[p][x];
        if (poke && nb == 1) begin
          start       = 1'b1;
          pixel_count = '0;
          tile_count  = 1;
        end
        if (p == te - 1) bcyc.push_back(cyc);
        nb++;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    if (npix > 0) begin
      psum_valid = 1'b1;
      psum_data  = rnd_word();
      @(posedge clk); #1;
    end
    psum_valid = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("flag_count", got_data.size(), npix);
    eovf = 1'b0;
    for (int x = 0; x < npix; x++) begin
      ew = '0;
      for (int l = 0; l < TM; l++) begin
        ew[l*FW +: FW] = model_lane(te, x, l, relu, sat);
        eovf |= sat;
      end
      if (x < got_data.size()) begin
        chk("word_data", got_data[x], ew);
        chk("flag_latency", got_cyc[x], bcyc[x] + 2);
      end
    end
    exp_done = (npix == 0) ? s_cyc + 1 : bcyc[npix-1] + 3;
    chk("done_cycle", done_cyc, exp_done);
    chk("busy_at_done", done_busy, 0);
    chk("ovf_sticky", ovf_sticky, eovf);
  endtask

  typedef struct {
    int              tiles;
    bit              relu;
    int              lane;
    logic [3:0][31:0] v;
    logic [31:0]     exp;
    bit              exp_ovf;
  } vec_t;

  function automatic vec_t mk(input int t, input bit r, input int l, input logic [31:0] v0,
                              input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] v3, input logic [31:0] e, input bit o);
    vec_t vt;
    vt.tiles = t; vt.relu = r; vt.lane = l;
    vt.v = {v3, v2, v1, v0};
    vt.exp = e; vt.exp_ovf = o;
    return vt;
  endfunction

  initial begin
    vec_t          tbl[10];
    logic [WW-1:0] w;

    tbl[0] = mk(1, 1, 2, 32'hFFFFFFF9, 0, 0, 0, 32'h00000000, 0);
    tbl[1] = mk(1, 0, 2, 32'hFFFFFFF9, 0, 0, 0, 32'hFFFFFFF9, 0);
    tbl[2] = mk(2, 0, 0, 32'h7FFFFFF0, 32'h20, 0, 0, 32'h7FFFFFFF, 1);
    tbl[3] = mk(2, 0, 5, 32'h80000010, 32'hFFFFFF00, 0, 0, 32'h80000000, 1);
    tbl[4] = mk(4, 0, 0, 5, 5, 5, 5, 32'd20, 0);
    tbl[5] = mk(3, 0, 3, 32'd10, 32'd20, 32'hFFFFFFFB, 0, 32'd25, 0);
    tbl[6] = mk(0, 0, 7, 32'd123, 0, 0, 0, 32'd123, 0);
    tbl[7] = mk(3, 0, 1, 32'h7FFFFFFF, 1, 32'hFFFFFFFF, 0, 32'h7FFFFFFE, 1);
    tbl[8] = mk(2, 1, 4, 32'hFFFFFFFD, 32'd10, 0, 0, 32'd7, 0);
    tbl[9] = mk(2, 1, 6, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h00000000, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_flag", CLP_output_flag, 0);
    chk("rst_output", CLP_output, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pass, four pixels back-to-back, lane0 = 1..4.
    for (int x = 0; x < 4; x++) begin
      pm[0][x] = '0;
      pm[0][x][31:0] = x + 1;
    end
    run_job(1, 4, 0, 0, 0);
    for (int x = 0; x < 4; x++) begin
      w = (x < got_data.size()) ? got_data[x] : '0;
      chk("t1_lane0", lane_of(w, 0), x + 1);
    end

    // Three passes, two pixels; a start pulse mid-job must be ignored.
    for (int p = 0; p < 3; p++)
      for (int x = 0; x < 2; x++) pm[p][x] = '0;
    pm[0][0][3*FW +: FW] = 10;
    pm[1][0][3*FW +: FW] = 20;
    pm[2][0][3*FW +: FW] = -5;
    pm[0][1][3*FW +: FW] = 1;
    pm[1][1][3*FW +: FW] = 2;
    pm[2][1][3*FW +: FW] = 3;
    run_job(3, 2, 0, 0, 1);
    w = (got_data.size() > 0) ? got_data[0] : '0;
    chk("t2_lane3_pix0", lane_of(w, 3), 25);
    w = (got_data.size() > 1) ? got_data[1] : '0;
    chk("t2_lane3_pix1", lane_of(w, 3), 6);

    // Single-pixel jobs exercise the same-address forwarding path.
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < 4; p++) begin
        for (int l = 0; l < TM; l++) pm[p][0][l*FW +: FW] = $urandom_range(0, 1000) - 500;
        pm[p][0][tbl[i].lane*FW +: FW] = tbl[i].v[p];
      end
      run_job(tbl[i].tiles, 1, tbl[i].relu, 0, 0);
      w = (got_data.size() > 0) ? got_data[0] : '0;
      chk("tbl_lane", lane_of(w, tbl[i].lane), tbl[i].exp);
      chk("tbl_ovf", ovf_sticky, tbl[i].exp_ovf);
    end

    for (int j = 0; j < 12; j++) begin
      for (int p = 0; p < 4; p++)
        for (int x = 0; x < 8; x++)
          for (int l = 0; l < TM; l++)
            pm[p][x][l*FW +: FW] = ($urandom_range(0, 3) == 0) ? $urandom
                                                                : $urandom_range(0, 2000) - 1000;
      run_job($urandom_range(0, 4), $urandom_range(1, 8), 1'($urandom),
              (j % 2 == 0) ? 0 : 35, 0);
    end

    // Abort mid-accumulation with reset, then a clean job afterwards.
    @(posedge clk); #1;
    tile_count = 2; pixel_count = 3; relu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; psum_valid = 1'b1; psum_data = rnd_word();
    @(posedge clk); #1;
    psum_data = rnd_word();
    @(posedge clk); #1;
    psum_valid = 1'b0;
    chk("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_flag", CLP_output_flag, 0);
    chk("abort_output", CLP_output, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ovf", ovf_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int x = 0; x < 3; x++) pm[0][x] = rnd_word();
    run_job(1, 3, 0, 0, 0);

    // Empty job: done one cycle after start, no flags.
    run_job(2, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
